// File: rtl/sr_pkg.sv
// Types shared by the serial link endpoints: the bit-order selector and the
// state encoding of the parallel-in/serial-out transmitter.
package sr_pkg;

  typedef enum logic {
    SHIFT_LEFT  = 1'b0,  // MSB first
    SHIFT_RIGHT = 1'b1   // LSB first
  } SHIFT_OP;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_e;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: takes a WIDTH-bit word over a
// valid/ready handshake and emits it one bit per shift_en cycle.
module piso_serializer
  import sr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  SHIFT_OP          op,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             shift_out,
  output logic             shift_valid,
  output logic             last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  piso_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  SHIFT_OP          op_q, op_d;

  logic is_shift;
  logic is_last;
  logic load_fire;

  assign is_shift  = (state_q == SHIFT);
  assign is_last   = is_shift && (cnt_q == '0);
  // Ready on the final bit lets the next word follow with no idle bubble.
  assign load_ready = !is_shift || (is_last && shift_en);
  assign load_fire  = load_valid && load_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      op_q    <= SHIFT_LEFT;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    if (load_fire) begin
      state_d = SHIFT;
      data_d  = load_data;
      cnt_d   = CNT_LOAD;
      op_d    = op;
    end else if (is_shift && shift_en) begin
      if (cnt_q != '0) begin
        if (op_q == SHIFT_LEFT) begin
          data_d = {data_q[WIDTH-2:0], 1'b0};
        end else begin
          data_d = {1'b0, data_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - 1'b1;
      end else begin
        state_d = IDLE;
        data_d  = '0;
      end
    end
  end

  assign shift_valid = is_shift;
  assign busy        = is_shift;
  assign last        = is_last;
  assign shift_out   = !is_shift ? 1'b0 :
                       (op_q == SHIFT_LEFT) ? data_q[WIDTH-1] : data_q[0];

endmodule
